// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: write-back controller for the single write port of the
// 32x32 integer register file. ALU results (no backpressure, fixed
// priority) are merged with long-latency results buffered in a small
// FIFO, and one registered write is issued per cycle. pend_mask flags
// every register that still has a FIFO entry outstanding.
//
// Optional feature: define REG_WB_FWD_EN to add two combinational
// forwarding read ports that observe the registered write stage.
module reg_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] pend_mask
`ifdef REG_WB_FWD_EN
  ,
  input  logic [4:0]  fwd_raddr_1,
  input  logic [4:0]  fwd_raddr_2,
  output logic        fwd_hit_1,
  output logic        fwd_hit_2,
  output logic [31:0] fwd_data_1,
  output logic [31:0] fwd_data_2
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // FIFO control state
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // FIFO storage (contents are qualified by vld_q, so no reset needed)
  logic [4:0]  fifo_rd_q   [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];

  // Registered write port
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic push;
  logic pop;
  logic sel_alu;

  // Ready depends on registered occupancy only, never on this cycle's pop.
  assign mem_ready = (cnt_q != CNT_W'(DEPTH));

  // Arbitration: ALU to a nonzero rd wins, otherwise drain the FIFO head.
  always_comb begin
    push      = mem_valid && mem_ready && (mem_rd != 5'd0);
    sel_alu   = alu_valid && (alu_rd != 5'd0);
    pop       = !sel_alu && (cnt_q != '0);
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (sel_alu) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fifo_rd_q[rptr_q];
      wr_data_d = fifo_data_q[rptr_q];
    end
  end

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop)  vld_d[rptr_q] = 1'b0;
    if (push) vld_d[wptr_q] = 1'b1;
  end

  // Control and write-port registers; reset empties the FIFO and kills wr_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage write on an accepted, non-x0 long-latency result.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= mem_rd;
      fifo_data_q[wptr_q] <= mem_data;
    end
  end

  // Pending mask: one-hot OR of rd over every occupied FIFO slot.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[fifo_rd_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef REG_WB_FWD_EN
  // Forwarding covers the output stage, which pend_mask does not.
  assign fwd_hit_1  = wr_en_q && (wr_addr_q == fwd_raddr_1) && (fwd_raddr_1 != 5'd0);
  assign fwd_hit_2  = wr_en_q && (wr_addr_q == fwd_raddr_2) && (fwd_raddr_2 != 5'd0);
  assign fwd_data_1 = fwd_hit_1 ? wr_data_q : 32'd0;
  assign fwd_data_2 = fwd_hit_2 ? wr_data_q : 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Testbench for reg_wb_ctrl (DEPTH=4): directed stimulus, expected writes
// queued at issue time and checked by an independent negedge monitor.
module tb_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;
`ifdef REG_WB_FWD_EN
  logic [4:0]  fwd_raddr_1, fwd_raddr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  reg_wb_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_mask (pend_mask)
`ifdef REG_WB_FWD_EN
    ,
    .fwd_raddr_1 (fwd_raddr_1),
    .fwd_raddr_2 (fwd_raddr_2),
    .fwd_hit_1   (fwd_hit_1),
    .fwd_hit_2   (fwd_hit_2),
    .fwd_data_1  (fwd_data_1),
    .fwd_data_2  (fwd_data_2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;   // expected visible cycle, -1 = order only
  } wr_t;

  wr_t aq[$];
  wr_t mq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mem_exact = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Record the writes the current inputs should cause, then advance one cycle.
  task automatic tick();
    wr_t e;
    if (alu_valid && alu_rd != 5'd0) begin
      e.a = alu_rd; e.d = alu_data; e.c = cyc + 1;
      aq.push_back(e);
    end
    if (mem_valid && mem_rd != 5'd0) begin
      e.a = mem_rd; e.d = mem_data; e.c = mem_exact ? cyc + 2 : -1;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard.
  wr_t   mon_e;
  bit    mon_have;
  string mon_src;
  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL alu_missed: write x%0d=0x%0h not seen, expected at cycle %0d (now %0d)",
               aq[0].a, aq[0].d, aq[0].c, cyc);
      mon_e = aq.pop_front();
    end
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      checks++;
      mon_have = 1'b1;
      if (aq.size() > 0 && aq[0].c == cyc) begin
        mon_e = aq.pop_front(); mon_src = "alu";
      end else if (mq.size() > 0) begin
        mon_e = mq.pop_front(); mon_src = "mem";
      end else begin
        mon_have = 1'b0;
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%0h at cycle %0d, expected no write",
                 wr_addr, wr_data, cyc);
      end
      if (mon_have) begin
        if (wr_addr !== mon_e.a || wr_data !== mon_e.d || (mon_e.c >= 0 && mon_e.c != cyc)) begin
          errors++;
          $display("FAIL %s_write: got x%0d=0x%0h at cycle %0d, expected x%0d=0x%0h at cycle %0d",
                   mon_src, wr_addr, wr_data, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef REG_WB_FWD_EN
    fwd_raddr_1 = '0; fwd_raddr_2 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_pend_mask", pend_mask, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
    chk("idle_mem_ready", {31'd0, mem_ready}, 32'd1);

    // ALU path: one result, visible next cycle, gone the cycle after
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("alu_followup_wr_en", {31'd0, wr_en}, 32'd0);

    // x0 filtering on both paths
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_0000;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hAAAA_5555;
    for (int i = 0; i < 2; i++) begin
      chk("x0_mem_ready", {31'd0, mem_ready}, 32'd1);
      tick();
      chk("x0_pend_mask", pend_mask, 32'd0);
      chk("x0_wr_en", {31'd0, wr_en}, 32'd0);
    end
    // x0 ALU result must not block a FIFO pop
    mem_exact = 1'b1;
    mem_rd = 5'd9; mem_data = 32'h0000_0099;
    chk("x0pop_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("x0pop_pend_mask", pend_mask, 32'h0000_0200);
    tick();
    tick();
    alu_valid = 1'b0;
    chk("x0pop_pend_clear", pend_mask, 32'd0);

    // Fill under continuous ALU writes to x1
    mem_exact = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int r = 2; r <= 5; r++) begin
      chk("fill_mem_ready", {31'd0, mem_ready}, 32'd1);
      mem_valid = 1'b1; mem_rd = 5'(r); mem_data = 32'h0000_0200 + r;
      alu_data = 32'hA000_0000 + r;
      tick();
    end
    mem_valid = 1'b0;
    chk("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("full_pend_mask", pend_mask, 32'h0000_003C);
    alu_data = 32'hA000_0010;
    tick();
    chk("stall_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("stall_pend_mask", pend_mask, 32'h0000_003C);
    // Release: drain in order on consecutive cycles
    alu_valid = 1'b0;
    for (int i = 0; i < mq.size(); i++) mq[i].c = cyc + 1 + i;
    tick();
    chk("drain_pend_1", pend_mask, 32'h0000_0038);
    chk("drain_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    chk("drain_pend_2", pend_mask, 32'h0000_0030);
    tick();
    chk("drain_pend_3", pend_mask, 32'h0000_0020);
    tick();
    chk("drain_pend_4", pend_mask, 32'd0);
    tick();

    // Streaming through the FIFO with pointer wrap
    mem_exact = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      chk("stream_mem_ready", {31'd0, mem_ready}, 32'd1);
      mem_valid = 1'b1; mem_rd = 5'(n); mem_data = 32'hC0DE_0000 + n;
      tick();
    end
    mem_valid = 1'b0;
    tick();
    tick();
    chk("stream_pend_mask", pend_mask, 32'd0);

    // Reset with three entries queued
    mem_exact = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hB0B0_0001;
    for (int r = 6; r <= 8; r++) begin
      mem_valid = 1'b1; mem_rd = 5'(r); mem_data = 32'h0000_0300 + r;
      tick();
    end
    mem_valid = 1'b0;
    chk("prerst_pend_mask", pend_mask, 32'h0000_01C0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_pend_mask", pend_mask, 32'd0);
    chk("midrst_mem_ready", {31'd0, mem_ready}, 32'd1);
    aq.delete();
    mq.delete();
    alu_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postrst_wr_en", {31'd0, wr_en}, 32'd0);
    end
    chk("postrst_pend_mask", pend_mask, 32'd0);

`ifdef REG_WB_FWD_EN
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
    tick();
    alu_valid = 1'b0;
    fwd_raddr_1 = 5'd7; fwd_raddr_2 = 5'd3;
    #1;
    chk("fwd_hit_1", {31'd0, fwd_hit_1}, 32'd1);
    chk("fwd_data_1", fwd_data_1, 32'h1234_5678);
    chk("fwd_hit_2_miss", {31'd0, fwd_hit_2}, 32'd0);
    chk("fwd_data_2_miss", fwd_data_2, 32'd0);
    fwd_raddr_1 = 5'd0; fwd_raddr_2 = 5'd7;
    #1;
    chk("fwd_hit_1_x0", {31'd0, fwd_hit_1}, 32'd0);
    chk("fwd_hit_2", {31'd0, fwd_hit_2}, 32'd1);
    chk("fwd_data_2", fwd_data_2, 32'h1234_5678);
    tick();
    chk("fwd_hit_2_idle", {31'd0, fwd_hit_2}, 32'd0);
`endif

    tick();
    tick();
    chk("end_alu_queue_empty", aq.size(), 32'd0);
    chk("end_mem_queue_empty", mq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
